// File: rtl/tx_frame_sched.sv
// rtl/tx_frame_sched.sv - byte-load and frame-clear sequencer for the 16-byte transmit shift buffer
module tx_frame_sched #(
    parameter int NREQ      = 4,
    parameter int MAX_BYTES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        buf_data,
    output logic              buf_en,
    output logic              buf_tfin,
    input  logic              buf_nf,
    input  logic [3:0]        buf_count,
    output logic              frame_valid,
    output logic [3:0]        frame_len,
    output logic [2:0]        frame_owner,
    input  logic              send_ack,
    output logic              err
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_READY,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [7:0]        data_q, data_d;
    logic              en_q, en_d;
    logic              tfin_q, tfin_d;
    logic              valid_q, valid_d;
    logic [3:0]        len_q, len_d;
    logic [2:0]        fowner_q, fowner_d;
    logic              err_q, err_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        owner_q, owner_d;
    logic              last_q, last_d;

    logic              any_req;
    logic [2:0]        pick_idx;
    logic              hi_found;
    logic [2:0]        hi_idx;
    logic [2:0]        lo_idx;
    logic              sel_req;
    logic [7:0]        sel_data;
    logic              sel_last;
    logic              cnt_mismatch;
    logic [2:0]        rr_next;

    // Round-robin pick (lowest index at/after rr_ptr, else lowest overall) and owner's request mux
    always_comb begin
        any_req  = 1'b0;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        sel_req  = 1'b0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (3'(j) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(j);
                end
                any_req = 1'b1;
                lo_idx  = 3'(j);
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
        for (int j = 0; j < NREQ; j++) begin
            if (3'(j) == owner_q) begin
                sel_req  = req[j];
                sel_data = req_data[j*8 +: 8];
                sel_last = req_last[j];
            end
        end
        cnt_mismatch = (buf_count != byte_cnt_q) || (!buf_nf && (byte_cnt_q < 4'd15));
        rr_next      = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
    end

    // Frame sequencing: next state and next values of every registered output
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        data_d     = data_q;
        en_d       = 1'b0;
        tfin_d     = 1'b0;
        valid_d    = valid_q;
        len_d      = len_q;
        fowner_d   = fowner_q;
        err_d      = err_q;
        byte_cnt_d = byte_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        last_d     = last_q;
        case (state_q)
            S_INIT: begin
                tfin_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (any_req) begin
                    owner_d = pick_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (sel_req) begin
                    en_d       = 1'b1;
                    data_d     = sel_data;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    last_d     = sel_last;
                    state_d    = S_GAP;
                    for (int j = 0; j < NREQ; j++) begin
                        gnt_d[j] = (3'(j) == owner_q);
                    end
                end
            end
            S_GAP: begin
                if (last_q || (byte_cnt_q == 4'(MAX_BYTES))) begin
                    valid_d  = 1'b1;
                    len_d    = byte_cnt_q;
                    fowner_d = owner_q;
                    if (cnt_mismatch) begin
                        err_d = 1'b1;
                    end
                    state_d = S_READY;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_READY: begin
                if (send_ack) begin
                    valid_d = 1'b0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                tfin_d     = 1'b1;
                byte_cnt_d = '0;
                last_d     = 1'b0;
                rr_ptr_d   = rr_next;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State and output registers; reset discards any open frame immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            gnt_q      <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
            tfin_q     <= 1'b0;
            valid_q    <= 1'b0;
            len_q      <= '0;
            fowner_q   <= '0;
            err_q      <= 1'b0;
            byte_cnt_q <= '0;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            data_q     <= data_d;
            en_q       <= en_d;
            tfin_q     <= tfin_d;
            valid_q    <= valid_d;
            len_q      <= len_d;
            fowner_q   <= fowner_d;
            err_q      <= err_d;
            byte_cnt_q <= byte_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
        end
    end

    assign gnt         = gnt_q;
    assign buf_data    = data_q;
    assign buf_en      = en_q;
    assign buf_tfin    = tfin_q;
    assign frame_valid = valid_q;
    assign frame_len   = len_q;
    assign frame_owner = fowner_q;
    assign err         = err_q;

endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
- Sequences the 16-byte transmit shift buffer: arbitrates several byte requesters, drives the buffer's byte-load pulse and frame-clear pulse, and hands completed frames to the downstream sender.
- Sits between the requester byte sources and the transmit buffer; the buffer itself has no clock or reset, so this block owns all of its timing.

Parameters:
- NREQ, 4, number of byte requesters (2..8).
- MAX_BYTES, 15, bytes per frame before forced close (1..15; 15 matches the buffer's saturating count).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  requester i has a byte valid.
- req_data  in  NREQ*8  byte of requester i at bits [8i+7:8i].
- req_last  in  NREQ  byte from requester i closes its frame.
- gnt  out  NREQ  one-hot; byte of requester i consumed this cycle.
- buf_data  out  8  byte to the buffer.
- buf_en  out  1  buffer load pulse (buffer is rising-edge sensitive).
- buf_tfin  out  1  buffer count-clear pulse.
- buf_nf  in  1  buffer not-full flag.
- buf_count  in  4  buffer byte count.
- frame_valid  out  1  frame complete, awaiting send.
- frame_len  out  4  bytes in the frame (1..MAX_BYTES).
- frame_owner  out  3  index of the requester owning the frame.
- send_ack  in  1  downstream has taken the frame.
- err  out  1  sticky count-mismatch flag.

Behaviour:
- Reset (rst_n low, asynchronous): state INIT; gnt=0, buf_en=0, buf_tfin=0, buf_data=0, frame_valid=0, frame_len=0, frame_owner=0, err=0, byte_cnt=0, rr_ptr=0.
- INIT: buf_tfin=1 for exactly one cycle after reset release (clears the unreset buffer count), then IDLE.
- IDLE: if any req, owner = first asserted req at or after rr_ptr (circular), then LOAD; otherwise stay.
- LOAD: if req[owner]=1:
  - buf_en=1, buf_data=req_data[owner], gnt[owner]=1, byte_cnt+1, capture last=req_last[owner].
  - Next state GAP.
  - If req[owner]=0: buf_en=0, stay in LOAD. Other requesters are never granted while a frame is open.
- GAP: buf_en=0 for one cycle (guaranteed low phase; peak rate is one byte per 2 cycles).
  - If last was captured or byte_cnt==MAX_BYTES, go to READY; otherwise LOAD.
- READY: frame_valid=1, frame_len=byte_cnt, frame_owner=owner; all held stable until send_ack.
  - On entry cycle, err is set if buf_count!=byte_cnt, or if buf_nf=0 while byte_cnt<15.
  - On send_ack=1, go to FLUSH; frame_valid drops the following cycle.
- FLUSH: buf_tfin=1 for one cycle, byte_cnt=0, rr_ptr=(owner+1) mod NREQ, then IDLE. buf_en is never high in the same cycle as buf_tfin.
- Outputs buf_en, buf_tfin and gnt are registered and glitch-free.
- send_ack outside READY is ignored.
- req_last on a byte that makes byte_cnt==MAX_BYTES: one close only, no extra state.
- Reset mid-frame: all outputs return to reset values immediately; buffer contents are discarded via INIT tfin.
- byte_cnt is 4 bits and never exceeds MAX_BYTES.
- err clears only on reset.

Test Plan:
- Reset release, no req → buf_tfin high exactly cycle 1, then IDLE; all other outputs 0.
- req[1]=1 with 3 bytes 0xA1,0xA2,0xA3, last on 3rd → 3 buf_en pulses 2 cycles apart; gnt=4'b0010 on each; frame_valid=1, frame_len=3, frame_owner=1; send_ack → one buf_tfin pulse, then IDLE.
- req[0] held high, never last → exactly 15 pulses, frame_len=15, buf_nf seen 0, err=0.
- req=4'b1111, each frame 1 byte with last → owners served in order 0,1,2,3,0; no grant to a non-owner mid-frame.
- Model buf_count stuck at 0 during a 2-byte frame → err=1 entering READY, stays 1 until rst_n low. Separately, assert rst_n low mid-LOAD → outputs 0 immediately, INIT tfin after release.
